cfs_apb_arb: RTL and testbench

Two-requester APB master that shares the Aligner register block's APB slave port between a software configuration port (requester 0) and a hardware service port (requester 1), e.g. an IRQ handler clearing IRQ bits. It sits in front of the register block, arbitrates round-robin, and sequences one APB transfer at a time through SETUP and ACCESS. It waits on `pready` and returns read data and error status to the granted requester. A watchdog aborts transfers the slave never completes.

---
 rtl/cfs_algn_pkg.sv | 19 +
 rtl/cfs_apb_arb_if.sv | 38 +++
 rtl/cfs_rr_arb2.sv | 32 +++
 rtl/cfs_apb_arb.sv | 123 ++++++++++++
 tb/tb_cfs_apb_arb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cfs_algn_pkg.sv
// Shared definitions for the Aligner APB front-end: arbiter state encoding and
// requester indices.
package cfs_algn_pkg;

    typedef enum logic [1:0] {
        CFS_APB_IDLE,
        CFS_APB_SETUP,
        CFS_APB_ACCESS,
        CFS_APB_RESP
    } cfs_apb_arb_state_t;

    localparam int unsigned CFS_REQ_SW = 0;
    localparam int unsigned CFS_REQ_HW = 1;

    function automatic logic [1:0] cfs_onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cfs_apb_arb_if.sv
// Requester and APB signal bundle for cfs_apb_arb. The master modport is the
// arbiter's view; the slave modport is the requesters plus the APB slave.
interface cfs_apb_arb_if #(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [1:0]                  req_valid;
    logic [1:0]                  req_write;
    logic [2*APB_ADDR_WIDTH-1:0] req_addr;
    logic [2*APB_DATA_WIDTH-1:0] req_wdata;
    logic [1:0]                  req_ready;
    logic [1:0]                  rsp_valid;
    logic [APB_DATA_WIDTH-1:0]   rsp_rdata;
    logic                        rsp_err;

    logic [APB_ADDR_WIDTH-1:0]   paddr;
    logic                        pwrite;
    logic                        psel;
    logic                        penable;
    logic [APB_DATA_WIDTH-1:0]   pwdata;
    logic                        pready;
    logic [APB_DATA_WIDTH-1:0]   prdata;
    logic                        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/cfs_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer. The pointer
// resets to the HW requester so the SW requester wins the first contention.
module cfs_rr_arb2
    import cfs_algn_pkg::*;
(
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_idx,
    output logic       gnt_any
);
    logic last_q;

    always_comb begin
        gnt_any = |req;
        gnt_idx = 1'(CFS_REQ_SW);
        if (req[CFS_REQ_SW] && req[CFS_REQ_HW]) begin
            gnt_idx = ~last_q;
        end else if (req[CFS_REQ_HW]) begin
            gnt_idx = 1'(CFS_REQ_HW);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            last_q <= 1'(CFS_REQ_HW);
        end else if (accept && gnt_any) begin
            last_q <= gnt_idx;
        end
    end
endmodule

// File: rtl/cfs_apb_arb.sv
// Two-requester APB master in front of the Aligner register block: round-robin
// grant, one SETUP/ACCESS transfer at a time, watchdog abort on a stuck slave.
module cfs_apb_arb
    import cfs_algn_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 15
) (
    input logic           pclk,
    input logic           preset,
    cfs_apb_arb_if.master bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    cfs_apb_arb_state_t state_q, state_d;

    logic                      owner_q;
    logic                      write_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic [WD_W-1:0]           wd_q;

    logic                      gnt_idx;
    logic                      gnt_any;
    logic                      accept;
    logic                      timed_out;
    logic                      sel_write;
    logic [APB_ADDR_WIDTH-1:0] sel_addr;
    logic [APB_DATA_WIDTH-1:0] sel_wdata;

    cfs_rr_arb2 u_rr (
        .pclk    (pclk),
        .preset  (preset),
        .req     (bus.req_valid),
        .accept  (accept),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_write = gnt_idx ? bus.req_write[1] : bus.req_write[0];
        sel_addr  = gnt_idx ? bus.req_addr[2*APB_ADDR_WIDTH-1:APB_ADDR_WIDTH]
                            : bus.req_addr[APB_ADDR_WIDTH-1:0];
        sel_wdata = gnt_idx ? bus.req_wdata[2*APB_DATA_WIDTH-1:APB_DATA_WIDTH]
                            : bus.req_wdata[APB_DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            CFS_APB_IDLE: begin
                if (gnt_any) begin
                    accept  = 1'b1;
                    state_d = CFS_APB_SETUP;
                end
            end
            CFS_APB_SETUP:  state_d = CFS_APB_ACCESS;
            CFS_APB_ACCESS: begin
                // A late pready on the final allowed cycle still completes normally.
                if (bus.pready) begin
                    state_d = CFS_APB_RESP;
                end else if (wd_q == WD_LAST) begin
                    timed_out = 1'b1;
                    state_d   = CFS_APB_RESP;
                end
            end
            CFS_APB_RESP:   state_d = CFS_APB_IDLE;
            default:        state_d = CFS_APB_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= CFS_APB_IDLE;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= gnt_idx;
                write_q <= sel_write;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wd_q    <= '0;
            end else if (state_q == CFS_APB_ACCESS && !bus.pready && wd_q != WD_MAX) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (state_q == CFS_APB_ACCESS) begin
                if (bus.pready) begin
                    rdata_q <= write_q ? '0 : bus.prdata;
                    err_q   <= bus.pslverr;
                end else if (timed_out) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.psel      = (state_q == CFS_APB_SETUP) || (state_q == CFS_APB_ACCESS);
        bus.penable   = (state_q == CFS_APB_ACCESS);
        bus.paddr     = addr_q;
        bus.pwrite    = write_q;
        bus.pwdata    = wdata_q;
        bus.req_ready = accept ? cfs_onehot2(gnt_idx) : '0;
        bus.rsp_valid = (state_q == CFS_APB_RESP) ? cfs_onehot2(owner_q) : '0;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end
endmodule

// File: tb/tb_cfs_apb_arb.sv
// Self-checking bench for cfs_apb_arb: directed scenarios plus randomized
// rounds checked cycle by cycle against a transaction-level model.
module tb_cfs_apb_arb;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic pclk;
    logic preset;
    int   n_tests;
    int   n_fail;

    // Model state: pending requests per requester and the last granted index.
    bit          pend[2];
    logic        p_write[2];
    logic [15:0] p_addr[2];
    logic [31:0] p_wdata[2];
    int          last_gnt;

    cfs_apb_arb_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    cfs_apb_arb #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            bus.req_valid[r]          = pend[r];
            bus.req_write[r]          = p_write[r];
            bus.req_addr[r*AW +: AW]  = p_addr[r];
            bus.req_wdata[r*DW +: DW] = p_wdata[r];
        end
    endtask

    // pready outside ACCESS must be ignored, so drive garbage there.
    task automatic noise();
        bus.pready  = 1'($urandom_range(0, 1));
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom_range(0, 1));
    endtask

    task automatic post_req(input int r, input logic wr, input logic [15:0] a, input logic [31:0] d);
        pend[r]    = 1'b1;
        p_write[r] = wr;
        p_addr[r]  = a;
        p_wdata[r] = d;
    endtask

    task automatic idle_cycle();
        @(negedge pclk);
        drive_reqs();
        noise();
        #1;
        check("idle_req_ready", 64'(bus.req_ready), 64'd0);
        check("idle_psel", 64'(bus.psel), 64'd0);
        check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    // One full transfer from grant to response. wt = wait states before pready.
    task automatic do_round(input int wt, input bit err, input logic [31:0] rd, input bit hang);
        int          w;
        int          n;
        logic        a_w;
        logic [15:0] a_addr;
        logic [31:0] a_wdata;
        logic [31:0] exp_rd;
        w = (pend[0] && pend[1]) ? (1 - last_gnt) : (pend[1] ? 1 : 0);
        last_gnt = w;
        a_w     = p_write[w];
        a_addr  = p_addr[w];
        a_wdata = p_wdata[w];
        exp_rd  = (hang || a_w) ? 32'd0 : rd;

        @(negedge pclk);
        drive_reqs();
        noise();
        #1;
        check("grant_req_ready", 64'(bus.req_ready), 64'(1) << w);
        check("grant_psel", 64'(bus.psel), 64'd0);
        check("grant_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        pend[w] = 1'b0;

        @(negedge pclk);
        drive_reqs();
        noise();
        #1;
        check("setup_psel", 64'(bus.psel), 64'd1);
        check("setup_penable", 64'(bus.penable), 64'd0);
        check("setup_paddr", 64'(bus.paddr), 64'(a_addr));
        check("setup_pwrite", 64'(bus.pwrite), 64'(a_w));
        check("setup_pwdata", 64'(bus.pwdata), 64'(a_wdata));
        check("setup_req_ready", 64'(bus.req_ready), 64'd0);

        n = hang ? int'(TO) : wt + 1;
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            drive_reqs();
            bus.pready  = (!hang && k == n - 1);
            bus.prdata  = bus.pready ? rd : $urandom;
            bus.pslverr = bus.pready ? err : 1'($urandom_range(0, 1));
            #1;
            check("access_psel", 64'(bus.psel), 64'd1);
            check("access_penable", 64'(bus.penable), 64'd1);
            check("access_paddr", 64'(bus.paddr), 64'(a_addr));
            check("access_pwdata", 64'(bus.pwdata), 64'(a_wdata));
            check("access_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end

        @(negedge pclk);
        drive_reqs();
        noise();
        #1;
        check("resp_rsp_valid", 64'(bus.rsp_valid), 64'(1) << w);
        check("resp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        check("resp_err", 64'(bus.rsp_err), 64'(hang | err));
        check("resp_psel", 64'(bus.psel), 64'd0);
        check("resp_penable", 64'(bus.penable), 64'd0);
        check("resp_req_ready", 64'(bus.req_ready), 64'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_gnt = 1;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_write[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0;
        end
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        preset = 1'b1;
        #1;
        check("rst_psel", 64'(bus.psel), 64'd0);
        check("rst_penable", 64'(bus.penable), 64'd0);
        check("rst_paddr", 64'(bus.paddr), 64'd0);
        check("rst_pwdata", 64'(bus.pwdata), 64'd0);
        check("rst_pwrite", 64'(bus.pwrite), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;

        // Contention for three rounds: grant order 0,1,0, then the leftover HW request.
        post_req(0, 1'b0, 16'h0004, 32'h0);
        post_req(1, 1'b1, 16'h0008, 32'hA5A5_0001);
        do_round(0, 1'b0, 32'h1111_0000, 1'b0);
        post_req(0, 1'b1, 16'h0000, 32'h0000_0101);
        do_round(1, 1'b0, 32'h2222_0000, 1'b0);
        post_req(1, 1'b0, 16'h0014, 32'h0);
        do_round(0, 1'b0, 32'h3333_0000, 1'b0);
        do_round(2, 1'b0, 32'h4444_0000, 1'b0);

        // Register-block style read with one wait state.
        post_req(0, 1'b0, 16'h000C, 32'h0);
        do_round(1, 1'b0, 32'h0003_0205, 1'b0);

        // Write to an unmapped address answered with pslverr.
        post_req(1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        do_round(0, 1'b1, 32'h5555_5555, 1'b0);

        // Stuck slave, then a normal transfer afterwards.
        post_req(0, 1'b0, 16'h0018, 32'h0);
        do_round(0, 1'b0, 32'h0, 1'b1);
        post_req(0, 1'b0, 16'h001C, 32'h0);
        do_round(TO - 1, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Reset asserted mid-ACCESS on a SW transfer.
        idle_cycle();
        post_req(0, 1'b0, 16'h0020, 32'h0);
        @(negedge pclk);
        drive_reqs();
        #1;
        check("rstx_req_ready", 64'(bus.req_ready), 64'd1);
        pend[0] = 1'b0;
        @(negedge pclk);
        drive_reqs();
        @(negedge pclk);
        bus.pready = 1'b0;
        #1;
        check("rstx_penable_before", 64'(bus.penable), 64'd1);
        #1;
        preset = 1'b1;
        #1;
        check("rstx_psel", 64'(bus.psel), 64'd0);
        check("rstx_penable", 64'(bus.penable), 64'd0);
        check("rstx_paddr", 64'(bus.paddr), 64'd0);
        check("rstx_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge pclk);
        preset   = 1'b0;
        last_gnt = 1;
        repeat (3) idle_cycle();
        post_req(0, 1'b0, 16'h0024, 32'h0);
        post_req(1, 1'b0, 16'h0028, 32'h0);
        check("rstx_model_winner", 64'(1 - last_gnt), 64'd0);
        do_round(0, 1'b0, 32'h7777_0000, 1'b0);
        do_round(0, 1'b0, 32'h8888_0000, 1'b0);

        // Randomized rounds.
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0)
                    post_req(r, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
            end
            if (!pend[0] && !pend[1])
                idle_cycle();
            else
                do_round(int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)), $urandom,
                         ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
